// File: rtl/pwm_sequencer.sv
// pwm_sequencer: steps the 16-bit PWM core through a programmable table
// of (period, active, repeat) entries, with optional looping and abort.
//
// Ports:
//   clk, reset      rising-edge clock, async active-low reset
//   wr_en/wr_addr   table write strobe and entry index
//   wr_period/wr_active/wr_repeat  entry contents
//   num_entries     profile length (0 = empty, >DEPTH clamps to DEPTH)
//   loop            wrap to entry 0 after the last entry
//   go / halt       start (IDLE only) / abort the profile
//   pwm_period/pwm_active  registered PERIOD/ACTIVE to the PWM core
//   pwm_start/pwm_stop     one-cycle pulses to the PWM core
//   busy, entry_idx, done  status
module pwm_sequencer #(
    parameter int DEPTH = 8,
    parameter int W     = 16,
    parameter int RW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_period,
    input  logic [W-1:0]  wr_active,
    input  logic [RW-1:0] wr_repeat,
    input  logic [AW:0]   num_entries,
    input  logic          loop,
    input  logic          go,
    input  logic          halt,
    output logic [W-1:0]  pwm_period,
    output logic [W-1:0]  pwm_active,
    output logic          pwm_start,
    output logic          pwm_stop,
    output logic          busy,
    output logic [AW-1:0] entry_idx,
    output logic          done
);

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STOP
    } state_t;

    state_t state;

    logic [W-1:0]  tbl_per [DEPTH];
    logic [W-1:0]  tbl_act [DEPTH];
    logic [RW-1:0] tbl_rep [DEPTH];

    logic [AW-1:0] idx;
    // cyc counts 0..P-1 inside a period, rep counts periods; together they
    // span P x R without needing a wide product counter.
    logic [W-1:0]  cyc;
    logic [RW-1:0] rep;
    logic [RW-1:0] run_rep;
    // Set when a halt forced the STOP cycle, so STOP returns to IDLE.
    logic          halting;

    logic [W-1:0]  ld_per;
    logic [W-1:0]  ld_act;
    logic [RW-1:0] ld_rep;
    logic [AW:0]   ne_c;
    logic [AW:0]   idx_inc;
    state_t        adv_state;
    logic [AW-1:0] adv_idx;
    logic          adv_done;
    logic          cyc_last;
    logic          rep_last;

    always_comb begin
        ld_per = tbl_per[idx];
        ld_act = (tbl_act[idx] > ld_per) ? ld_per : tbl_act[idx];
        ld_rep = (tbl_rep[idx] == '0) ? RW'(1) : tbl_rep[idx];
        ne_c = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
        idx_inc = {1'b0, idx} + (AW+1)'(1);
        adv_state = S_IDLE;
        adv_idx = idx;
        adv_done = 1'b0;
        if (idx_inc < ne_c) begin
            adv_state = S_LOAD;
            adv_idx = idx_inc[AW-1:0];
        end else if (loop) begin
            adv_state = S_LOAD;
            adv_idx = '0;
        end else begin
            adv_done = 1'b1;
        end
        cyc_last = (cyc == pwm_period - W'(1));
        rep_last = (rep == run_rep - RW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_per[i] <= '0;
                tbl_act[i] <= '0;
                tbl_rep[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_per[wr_addr] <= wr_period;
            tbl_act[wr_addr] <= wr_active;
            tbl_rep[wr_addr] <= wr_repeat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            cyc        <= '0;
            rep        <= '0;
            run_rep    <= '0;
            halting    <= 1'b0;
            pwm_period <= '0;
            pwm_active <= '0;
            pwm_start  <= 1'b0;
            pwm_stop   <= 1'b0;
            busy       <= 1'b0;
            entry_idx  <= '0;
            done       <= 1'b0;
        end else begin
            pwm_start <= 1'b0;
            pwm_stop  <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go && !halt && num_entries != '0) begin
                        state   <= S_LOAD;
                        idx     <= '0;
                        busy    <= 1'b1;
                        halting <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (halt) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        pwm_period <= ld_per;
                        pwm_active <= ld_act;
                        entry_idx  <= idx;
                        cyc        <= '0;
                        rep        <= '0;
                        run_rep    <= ld_rep;
                        // A zero-period entry is skipped without touching
                        // the PWM core.
                        if (ld_per == '0) begin
                            state <= adv_state;
                            idx   <= adv_idx;
                            busy  <= (adv_state != S_IDLE);
                            done  <= adv_done;
                        end else begin
                            state     <= S_RUN;
                            pwm_start <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state    <= S_STOP;
                        pwm_stop <= 1'b1;
                        halting  <= 1'b1;
                    end else if (cyc_last) begin
                        cyc <= '0;
                        if (rep_last) begin
                            state    <= S_STOP;
                            pwm_stop <= 1'b1;
                        end else begin
                            rep <= rep + RW'(1);
                        end
                    end else begin
                        cyc <= cyc + W'(1);
                    end
                end
                S_STOP: begin
                    if (halt || halting) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        halting <= 1'b0;
                    end else begin
                        state <= adv_state;
                        idx   <= adv_idx;
                        busy  <= (adv_state != S_IDLE);
                        done  <= adv_done;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer: scoreboard bench for pwm_sequencer; expected
// start/stop/done events are queued with their cycle stamps.
module tb_pwm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_period = '0;
    logic [15:0] wr_active = '0;
    logic [7:0]  wr_repeat = '0;
    logic [3:0]  num_entries = '0;
    logic        loop = 1'b0;
    logic        go = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pwm_period;
    logic [15:0] pwm_active;
    logic        pwm_start;
    logic        pwm_stop;
    logic        busy;
    logic [2:0]  entry_idx;
    logic        done;

    pwm_sequencer dut (
        .clk         (clk),
        .reset       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_period   (wr_period),
        .wr_active   (wr_active),
        .wr_repeat   (wr_repeat),
        .num_entries (num_entries),
        .loop        (loop),
        .go          (go),
        .halt        (halt),
        .pwm_period  (pwm_period),
        .pwm_active  (pwm_active),
        .pwm_start   (pwm_start),
        .pwm_stop    (pwm_stop),
        .busy        (busy),
        .entry_idx   (entry_idx),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int t;
        int per;
        int act;
        int idx;
    } evt_t;

    evt_t q[$];
    int   cyc_n = 0;
    int   tm = 0;
    int   n_total = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic take(input int kind);
        evt_t e;
        chk("evt_pending", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("evt_kind", kind, e.kind);
            chk("evt_time", cyc_n, e.t);
            if (kind == 0) begin
                chk("pwm_period", pwm_period, e.per);
                chk("pwm_active", pwm_active, e.act);
                chk("entry_idx", entry_idx, e.idx);
            end
            if (kind == 2) chk("busy_at_done", busy, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pwm_start) take(0);
            if (pwm_stop) take(1);
            if (done) take(2);
        end
    end

    // Expected timeline: LOAD at tm, start tm+1, stop tm+1+P*R.
    task automatic push_entry(input int p, input int a, input int r, input int ix);
        int rr;
        rr = (r == 0) ? 1 : r;
        if (p == 0) begin
            tm += 1;
        end else begin
            q.push_back('{0, tm + 1, p, (a > p) ? p : a, ix});
            q.push_back('{1, tm + 1 + p * rr, 0, 0, 0});
            tm += p * rr + 2;
        end
    endtask

    task automatic push_done();
        q.push_back('{2, tm, 0, 0, 0});
    endtask

    task automatic wr(input int a, input int p, input int ac, input int r);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 3'(a);
        wr_period = 16'(p);
        wr_active = 16'(ac);
        wr_repeat = 8'(r);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        go = 1'b1;
        tm = cyc_n + 1;
    endtask

    task automatic unkick();
        @(negedge clk);
        go = 1'b0;
        chk("busy_after_go", busy, 1);
    endtask

    task automatic wait_until(input int s);
        int n;
        n = 0;
        while (cyc_n < s && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    int k;

    initial begin
        #12;
        chk("rst_period", pwm_period, 0);
        chk("rst_active", pwm_active, 0);
        chk("rst_start", pwm_start, 0);
        chk("rst_stop", pwm_stop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", entry_idx, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // Single entry
        wr(0, 12, 6, 3);
        num_entries = 4'd1;
        kick();
        push_entry(12, 6, 3, 0);
        push_done();
        unkick();
        drain(100);

        // Three entries, with go re-asserted mid-run
        wr(0, 12, 6, 2);
        wr(1, 12, 3, 1);
        wr(2, 12, 9, 1);
        num_entries = 4'd3;
        kick();
        k = tm;
        push_entry(12, 6, 2, 0);
        push_entry(12, 3, 1, 1);
        push_entry(12, 9, 1, 2);
        push_done();
        unkick();
        wait_until(k + 10);
        go = 1'b1;
        wait_until(k + 30);
        go = 1'b0;
        drain(100);

        // Zero period skipped, active clamped, repeat 0 as 1
        wr(0, 0, 5, 2);
        wr(1, 12, 15, 0);
        wr(2, 5, 2, 1);
        num_entries = 4'd12;
        loop = 1'b0;
        num_entries = 4'd3;
        kick();
        push_entry(0, 5, 2, 0);
        push_entry(12, 15, 0, 1);
        push_entry(5, 2, 1, 2);
        push_done();
        unkick();
        drain(100);

        // Clamp of num_entries above DEPTH: 8 entries, last 5 zero-period
        wr(3, 0, 0, 0);
        wr(4, 0, 0, 0);
        wr(5, 0, 0, 0);
        wr(6, 0, 0, 0);
        wr(7, 0, 0, 0);
        num_entries = 4'd15;
        kick();
        push_entry(0, 5, 2, 0);
        push_entry(12, 15, 0, 1);
        push_entry(5, 2, 1, 2);
        for (int i = 3; i < 8; i++) push_entry(0, 0, 0, i);
        push_done();
        unkick();
        drain(100);

        // Loop, write to running entry, then halt
        wr(0, 6, 3, 1);
        wr(1, 4, 1, 2);
        num_entries = 4'd2;
        loop = 1'b1;
        kick();
        k = tm;
        push_entry(6, 3, 1, 0);
        push_entry(4, 1, 2, 1);
        push_entry(20, 3, 1, 0);
        q.push_back('{0, tm + 1, 4, 1, 1});
        unkick();
        wait_until(k + 2);
        wr(0, 20, 3, 1);
        wait_until(k + 45);
        halt = 1'b1;
        q.push_back('{1, k + 46, 0, 0, 0});
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);
        chk("halt_busy", busy, 0);
        chk("halt_done", done, 0);
        loop = 1'b0;
        drain(20);

        // Async reset mid-run
        num_entries = 4'd1;
        kick();
        q.push_back('{0, tm + 1, 20, 3, 0});
        unkick();
        wait_until(tm + 1);
        chk("pre_rst_start", pwm_start, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start", pwm_start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_period", pwm_period, 0);
        chk("arst_active", pwm_active, 0);
        q.delete();
        #3 rst_n = 1'b1;

        // Cleared table: zero-period entries only, done with no start
        kick();
        push_entry(0, 0, 0, 0);
        push_done();
        unkick();
        drain(20);
        num_entries = 4'd3;
        kick();
        for (int i = 0; i < 3; i++) push_entry(0, 0, 0, i);
        push_done();
        unkick();
        drain(20);
        chk("end_period", pwm_period, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Profile sequencer that drives the existing 16-bit PWM core's PERIOD/ACTIVE/start/stop inputs from a small programmable table of (period, active, repeat) entries. It loads each entry, starts the PWM core, and holds it for period × repeat clocks. It then stops the core and advances to the next entry, optionally looping. It sits directly in front of the PWM core and replaces hand-sequenced start/stop/reconfigure traffic.

## Interface
- DEPTH, 8, number of table entries (index width 3).
- W, 16, period/active width; matches the PWM core.
- RW, 8, repeat-count width.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  3  table entry index.
- wr_period  in  W  entry period in clocks.
- wr_active  in  W  entry active clocks.
- wr_repeat  in  RW  periods to hold the entry.
- num_entries  in  4  entries in the profile; 0 means empty, values above 8 are treated as 8.
- loop  in  1  1 means wrap to entry 0 after the last entry; sampled at end of each entry.
- go  in  1  start the profile; level, sampled in IDLE only.
- halt  in  1  abort the profile.
- pwm_period  out  W  to PWM core PERIOD.
- pwm_active  out  W  to PWM core ACTIVE.
- pwm_start  out  1  one-cycle start pulse to PWM core.
- pwm_stop  out  1  one-cycle stop pulse to PWM core.
- busy  out  1  high in any state except IDLE.
- entry_idx  out  3  entry currently loaded.
- done  out  1  one-cycle pulse when a non-looping profile completes.

## Operation
- **Table:** DEPTH × (W+W+RW) registers. A write takes effect on the next edge and is allowed while busy. An entry is sampled only in LOAD, so a write to the running entry affects its next load only.
- **States:** IDLE, LOAD, RUN, STOP.
- **IDLE:**
  - If go=1, halt=0 and num_entries≠0, go to LOAD with idx=0.
  - Otherwise remain in IDLE.
- **LOAD (1 cycle):**
  - Register pwm_period=table[idx].period.
  - Register pwm_active=min(active, period); active above period is clamped to period.
  - Register entry_idx=idx.
  - Clear the cycle and repeat counters.
  - Period=0: skip RUN and go directly to advance, with no start or stop pulse.
  - Otherwise go to RUN.
- **RUN:**
  - pwm_start=1 in the first RUN cycle only.
  - A cycle counter runs 0..P-1, then the repeat counter increments.
  - Repeat=0 is treated as 1.
  - RUN lasts exactly P×R cycles, then goes to STOP.
- **STOP (1 cycle):**
  - pwm_stop=1.
  - Then advance:
    - If idx+1 < num_entries (clamped), go to LOAD with idx+1.
    - Else if loop=1, go to LOAD with idx=0.
    - Else go to IDLE and pulse done in the first IDLE cycle.
- **halt:**
  - Highest priority in any non-IDLE state.
  - If in RUN, the next cycle emits pwm_stop=1 (a STOP cycle), then goes to IDLE.
  - If in LOAD or STOP, go straight to IDLE with no stop pulse.
  - done is never asserted on halt.
- go while busy is ignored. halt in IDLE is a no-op.
- The counters are W+RW wide internally, so P×R never overflows.

## Timing
- **Reset:** state IDLE; all outputs 0; table, counters and idx cleared. Reset is asynchronous, so reset mid-RUN drops pwm_start, pwm_stop and busy immediately, with no stop pulse.
- **Start latency:** go sampled high at edge k gives LOAD in cycle k→k+1. pwm_period and pwm_active are valid after edge k+1. pwm_start is high in cycle k+1→k+2. busy goes high after edge k.
- **Per entry:** P×R RUN cycles, plus 1 STOP cycle, plus 1 LOAD cycle. Consecutive pwm_start pulses are P×R+2 cycles apart.
- **Stop pulse:** pwm_stop occurs exactly P×R cycles after that entry's pwm_start.
- **Completion:** done and busy=0 are observed in the cycle after the last pwm_stop.
- **Outputs:** pwm_period and pwm_active hold their last loaded values in IDLE until the next LOAD or reset.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Single entry:** entry0=(12,6,3), num_entries=1, loop=0, go → pwm_period=12, pwm_active=6; one pwm_start; pwm_stop 36 cycles later; done 1 cycle after pwm_stop; busy low.
- **Three entries:** (12,6,2), (12,3,1), (12,9,1), loop=0 → pwm_start at t0, t0+26, t0+40; entry_idx 0,1,2; done at t0+53.
- **Loop and halt:** two entries, loop=1 → entry_idx wraps 1→0 with 2-cycle gap. halt mid-RUN → pwm_stop next cycle, busy low the cycle after, done never asserted.
- **Edge-case entries:** period=0 entry → skipped, no start or stop pulse. active=15, period=12 → pwm_active=12. repeat=0 → behaves as 1.
- **Async reset:** reset low mid-RUN → all outputs 0 immediately. After release, the table reads back as zero, so go with all-zero entries yields no pwm_start.
- **Busy interactions:** go re-asserted while busy → ignored. Write entry0 period=20 during a looping run → next load of entry0 shows pwm_period=20; the current entry is unaffected.
